// File: rtl/fa_serial_adder_if.sv
// Operand/result bundle for fa_serial_adder; the sub signal exists only when
// FA_SERIAL_SUB_EN is defined.
interface fa_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef FA_SERIAL_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
`ifdef FA_SERIAL_SUB_EN
      output sub,
`endif
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
`ifdef FA_SERIAL_SUB_EN
      input  sub,
`endif
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/fa_serial_adder.sv
// Slice-serial WIDTH-bit adder, SLICE bits per clock, LSB slice first.
// Optional subtract mode is enabled by defining FA_SERIAL_SUB_EN.
module fa_serial_adder #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic            clk,
   input  logic            reset,
   fa_serial_adder_if.slave bus
);

   localparam int N     = WIDTH / SLICE;
   localparam int CNT_W = $clog2(N + 1);

   typedef enum logic [0:0] {IDLE, RUN} state_t;

   state_t           state_q, state_nx;
   logic [WIDTH-1:0] a_q, a_nx;
   logic [WIDTH-1:0] b_q, b_nx;
   logic [WIDTH-1:0] sum_q, sum_nx;
   logic             carry_q, carry_nx;
   logic [CNT_W-1:0] cnt_q, cnt_nx;
   logic             busy_q, busy_nx;
   logic             done_q, done_nx;
   logic             cout_q, cout_nx;
   logic             ovf_q, ovf_nx;

   logic [SLICE:0]   slice_res;
   int               idx;

   function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y,
                                                input logic             c);
      return {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, c};
   endfunction

   // Carry into the MSB is recovered as x^y^s of that bit, so no extra slice tap is needed.
   function automatic logic signed_ovf(input logic x_msb, input logic y_msb,
                                       input logic s_msb, input logic c_out);
      return x_msb ^ y_msb ^ s_msb ^ c_out;
   endfunction

   assign idx       = int'(cnt_q) * SLICE;
   assign slice_res = slice_add(a_q[idx +: SLICE], b_q[idx +: SLICE], carry_q);

   always_comb begin
      state_nx = state_q;
      a_nx     = a_q;
      b_nx     = b_q;
      sum_nx   = sum_q;
      carry_nx = carry_q;
      cnt_nx   = cnt_q;
      busy_nx  = busy_q;
      done_nx  = done_q;
      cout_nx  = cout_q;
      ovf_nx   = ovf_q;
      case (state_q)
         IDLE: begin
            done_nx = 1'b0;
            if (bus.start) begin
               a_nx = bus.a;
`ifdef FA_SERIAL_SUB_EN
               if (bus.sub) begin
                  b_nx     = ~bus.b;
                  carry_nx = 1'b1;
               end else begin
                  b_nx     = bus.b;
                  carry_nx = bus.cin;
               end
`else
               b_nx     = bus.b;
               carry_nx = bus.cin;
`endif
               cnt_nx   = '0;
               busy_nx  = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            sum_nx[idx +: SLICE] = slice_res[SLICE-1:0];
            carry_nx             = slice_res[SLICE];
            cnt_nx               = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(N - 1)) begin
               cout_nx  = slice_res[SLICE];
               ovf_nx   = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1],
                                     slice_res[SLICE-1], slice_res[SLICE]);
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_nx;
         a_q     <= a_nx;
         b_q     <= b_nx;
         sum_q   <= sum_nx;
         carry_q <= carry_nx;
         cnt_q   <= cnt_nx;
         busy_q  <= busy_nx;
         done_q  <= done_nx;
         cout_q  <= cout_nx;
         ovf_q   <= ovf_nx;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_fa_serial_adder.sv
// Scoreboard bench for fa_serial_adder: three configurations (16/4, 8/1, 8/8)
// checked against an integer-arithmetic reference model.
module tb_fa_serial_adder;

   localparam int WA [3] = '{16, 8, 8};
   localparam int SA [3] = '{4, 1, 8};
   localparam int NA [3] = '{4, 8, 1};

   typedef struct {
      logic [15:0] s;
      logic        co;
      logic        ov;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        st [3];
   logic [15:0] av [3];
   logic [15:0] bv [3];
   logic        ci [3];
   logic        sb [3];

   logic [2:0]       busy_w, done_w, cout_w, ovf_w;
   logic [2:0][15:0] sum_w;

   for (genvar g = 0; g < 3; g++) begin : gd
      localparam int W = WA[g];
      localparam int S = SA[g];
      fa_serial_adder_if #(.WIDTH(W)) ifc ();
      assign ifc.start = st[g];
      assign ifc.a     = av[g][W-1:0];
      assign ifc.b     = bv[g][W-1:0];
      assign ifc.cin   = ci[g];
`ifdef FA_SERIAL_SUB_EN
      assign ifc.sub   = sb[g];
`endif
      fa_serial_adder #(.WIDTH(W), .SLICE(S)) dut (
         .clk  (clk),
         .reset(reset),
         .bus  (ifc)
      );
      assign busy_w[g] = ifc.busy;
      assign done_w[g] = ifc.done;
      assign cout_w[g] = ifc.cout;
      assign ovf_w[g]  = ifc.ovf;
      assign sum_w[g]  = 16'(ifc.sum);
   end

   // Reference: plain integer add/subtract, signed range check for overflow.
   function automatic ent_t model(int g, logic [15:0] a, logic [15:0] b,
                                  logic c, logic s);
      ent_t   e;
      longint full, half, ua, ub, sa, sbb, r, sr;
      full = longint'(1) << WA[g];
      half = full >> 1;
      ua   = longint'(a) & (full - 1);
      ub   = longint'(b) & (full - 1);
      sa   = (ua >= half) ? ua - full : ua;
      sbb  = (ub >= half) ? ub - full : ub;
      if (s) begin
         r    = ua - ub;
         e.co = (ua >= ub);
         sr   = sa - sbb;
      end else begin
         r    = ua + ub + longint'(c);
         e.co = (r >= full);
         sr   = sa + sbb + longint'(c);
      end
      e.ov = (sr < -half) || (sr > half - 1);
      e.s  = 16'(r & (full - 1));
      return e;
   endfunction

   ent_t q [3][$];
   int   cyc = 0;
   int   rst_cnt = 0;
   int   acc_e [3];
   int   free_e [3];
   bit   finish_req = 1'b0;

   // Model timing: which edges accept a start, flushed by reset.
   always @(posedge clk) begin
      for (int g = 0; g < 3; g++) begin
         logic sub_v;
`ifdef FA_SERIAL_SUB_EN
         sub_v = sb[g];
`else
         sub_v = 1'b0;
`endif
         if (reset) begin
            q[g].delete();
            acc_e[g]  = -100000;
            free_e[g] = cyc + 1;
         end else if (st[g] && cyc >= free_e[g]) begin
            q[g].push_back(model(g, av[g], bv[g], ci[g], sub_v));
            acc_e[g]  = cyc;
            free_e[g] = cyc + NA[g] + 1;
         end
      end
      if (reset) rst_cnt++;
      cyc++;
   end

   int          tests = 0;
   int          fails = 0;
   int          seen_rst = 0;
   logic [15:0] hs [3];
   logic        hco [3];
   logic        hov [3];

   task automatic chk(string nm, int g, logic [15:0] act, logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d cyc=%0d got %h want %h", nm, g, cyc, act, exp);
      end
   endtask

   // Monitor: control timing every cycle; results popped when done is seen.
   always @(negedge clk) begin
      if (rst_cnt != seen_rst) begin
         seen_rst = rst_cnt;
         for (int g = 0; g < 3; g++) begin
            hs[g] = '0; hco[g] = 1'b0; hov[g] = 1'b0;
         end
      end
      if (rst_cnt > 0) begin
         for (int g = 0; g < 3; g++) begin
            int  d;
            logic bexp, dexp;
            d    = cyc - acc_e[g];
            bexp = (d >= 1) && (d <= NA[g]);
            dexp = (d == NA[g] + 1);
            chk("busy", g, 16'(busy_w[g]), 16'(bexp));
            chk("done", g, 16'(done_w[g]), 16'(dexp));
            if (done_w[g]) begin
               if (q[g].size() == 0) begin
                  chk("spurious_done", g, 16'(1), 16'(0));
               end else begin
                  ent_t e;
                  e = q[g].pop_front();
                  hs[g] = e.s; hco[g] = e.co; hov[g] = e.ov;
               end
            end
            if (!bexp) begin
               chk("sum", g, sum_w[g], hs[g]);
               chk("cout", g, 16'(cout_w[g]), 16'(hco[g]));
               chk("ovf", g, 16'(ovf_w[g]), 16'(hov[g]));
            end
         end
      end
      if (finish_req) begin
         for (int g = 0; g < 3; g++) chk("pending_at_end", g, 16'(q[g].size()), 16'(0));
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
   end

   task automatic op(int g, logic [15:0] a, logic [15:0] b, logic c, logic s);
      @(negedge clk);
      av[g] = a; bv[g] = b; ci[g] = c; sb[g] = s; st[g] = 1'b1;
      @(negedge clk);
      st[g] = 1'b0;
      av[g] = 16'($urandom); bv[g] = 16'($urandom);
      ci[g] = 1'($urandom);  sb[g] = 1'($urandom);
      repeat (NA[g]) @(negedge clk);
   endtask

   initial begin
      for (int g = 0; g < 3; g++) begin
         st[g] = 1'b0; av[g] = '0; bv[g] = '0; ci[g] = 1'b0; sb[g] = 1'b0;
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      op(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
      op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      op(0, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
      op(0, 16'h8000, 16'h8000, 1'b0, 1'b0);
      op(1, 16'h0080, 16'h0080, 1'b0, 1'b0);
      op(2, 16'h0080, 16'h0080, 1'b0, 1'b0);

      // Start held high with operands churning: later starts land in done cycles.
      @(negedge clk);
      st[0] = 1'b1; av[0] = 16'h1111; bv[0] = 16'h2222; ci[0] = 1'b0; sb[0] = 1'b0;
      repeat (12) begin
         @(negedge clk);
         av[0] = 16'($urandom); bv[0] = 16'($urandom);
      end
      st[0] = 1'b0;
      repeat (6) @(negedge clk);

      // Reset at the second RUN edge, then a normal operation.
      @(negedge clk);
      av[0] = 16'hABCD; bv[0] = 16'h1357; ci[0] = 1'b1; sb[0] = 1'b0; st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      op(0, 16'h00F0, 16'h0F0F, 1'b0, 1'b0);

`ifdef FA_SERIAL_SUB_EN
      op(0, 16'h0005, 16'h0007, 1'b1, 1'b1);
      op(0, 16'h8000, 16'h0001, 1'b0, 1'b1);
`endif

      for (int i = 0; i < 30; i++) begin
         for (int g = 0; g < 3; g++) begin
            op(g, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         end
      end

      repeat (5) @(negedge clk);
      finish_req = 1'b1;
      repeat (3) @(negedge clk);
      $display("FAIL bench_end monitor did not finish: got running want stopped");
      $fatal(1);
   end

endmodule
